// File: rtl/i2c_target.sv
// I2C target answering one 7-bit address and moving bytes over rx/tx pulse handshakes.
// Optional macro I2C_TARGET_CLOCK_STRETCH_EN: stretch SCL while read data is not yet available.
module i2c_target #(
  parameter logic [6:0] TARGET_ADDR = 7'h1F
) (
  input  logic       clock,
  input  logic       reset,
  inout  wire        i2c_scl,
  inout  wire        i2c_sda,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ack,
  output logic       busy,
  output logic       tx_underrun,
  output logic [2:0] dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ADDR     = 3'd1,
    ADDR_ACK = 3'd2,
    WR_BYTE  = 3'd3,
    WR_ACK   = 3'd4,
    RD_BYTE  = 3'd5,
    RD_ACK   = 3'd6
  } state_e;

  state_e     state_q;
  logic [3:0] bit_cnt_q;
  logic [7:0] shift_q;
  logic       rw_q;
  logic       nack_q;
  logic       load_q;
  logic       sda_drive_q;
  logic       busy_q;
  logic [7:0] rx_data_q;
  logic       rx_upd_q;
  logic       rx_valid_q;
  logic       tx_ack_q;
  logic       tx_underrun_q;
  logic [2:0] scl_sync_q;
  logic [2:0] sda_sync_q;

  logic scl_s, scl_p, sda_s, sda_p;
  logic scl_rise, scl_fall, start_det, stop_det;

  // Bits [1] are the synchronized levels, bits [2] the previous sample for edge detection.
  always_ff @(posedge clock) begin
    if (reset) begin
      scl_sync_q <= 3'b111;
      sda_sync_q <= 3'b111;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], i2c_scl};
      sda_sync_q <= {sda_sync_q[1:0], i2c_sda};
    end
  end

  assign scl_s     = scl_sync_q[1];
  assign scl_p     = scl_sync_q[2];
  assign sda_s     = sda_sync_q[1];
  assign sda_p     = sda_sync_q[2];
  assign scl_rise  = scl_s & ~scl_p;
  assign scl_fall  = ~scl_s & scl_p;
  assign start_det = scl_s & scl_p & sda_p & ~sda_s;
  assign stop_det  = scl_s & scl_p & ~sda_p & sda_s;

  // Handshake: rx_valid, tx_ack and tx_underrun are one-clock pulses; tx_data is taken in the
  // cycle tx_ack pulses, so tx_valid must stay high until then (no back-pressure on rx).
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      bit_cnt_q     <= 4'd0;
      shift_q       <= 8'h00;
      rw_q          <= 1'b0;
      nack_q        <= 1'b0;
      load_q        <= 1'b0;
      sda_drive_q   <= 1'b0;
      busy_q        <= 1'b0;
      rx_data_q     <= 8'h00;
      rx_upd_q      <= 1'b0;
      rx_valid_q    <= 1'b0;
      tx_ack_q      <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      rx_upd_q      <= 1'b0;
      rx_valid_q    <= rx_upd_q;
      tx_ack_q      <= 1'b0;
      tx_underrun_q <= 1'b0;
      if (start_det) begin
        state_q     <= ADDR;
        bit_cnt_q   <= 4'd0;
        shift_q     <= 8'h00;
        load_q      <= 1'b0;
        sda_drive_q <= 1'b0;
      end else if (stop_det) begin
        state_q     <= IDLE;
        bit_cnt_q   <= 4'd0;
        load_q      <= 1'b0;
        sda_drive_q <= 1'b0;
        busy_q      <= 1'b0;
      end else begin
        unique case (state_q)
          IDLE: ;
          ADDR: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              bit_cnt_q <= 4'd0;
              if (shift_q[7:1] == TARGET_ADDR) begin
                state_q     <= ADDR_ACK;
                sda_drive_q <= 1'b1;
                busy_q      <= 1'b1;
                rw_q        <= shift_q[0];
              end else begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end
            end
          end
          ADDR_ACK: begin
            if (scl_fall) begin
              sda_drive_q <= 1'b0;
              bit_cnt_q   <= 4'd0;
              if (rw_q) begin
                state_q <= RD_BYTE;
                load_q  <= 1'b1;
              end else begin
                state_q <= WR_BYTE;
              end
            end
          end
          WR_BYTE: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], sda_s};
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                rx_data_q <= {shift_q[6:0], sda_s};
                rx_upd_q  <= 1'b1;
              end
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              state_q     <= WR_ACK;
              sda_drive_q <= 1'b1;
              bit_cnt_q   <= 4'd0;
            end
          end
          WR_ACK: begin
            if (scl_fall) begin
              state_q     <= WR_BYTE;
              sda_drive_q <= 1'b0;
            end
          end
          RD_BYTE: begin
            if (load_q) begin
              if (tx_valid) begin
                shift_q     <= tx_data;
                tx_ack_q    <= 1'b1;
                sda_drive_q <= ~tx_data[7];
                load_q      <= 1'b0;
              end else begin
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
                load_q <= 1'b1;
`else
                shift_q       <= 8'hFF;
                tx_underrun_q <= 1'b1;
                sda_drive_q   <= 1'b0;
                load_q        <= 1'b0;
`endif
              end
            end else if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                state_q     <= RD_ACK;
                sda_drive_q <= 1'b0;
                bit_cnt_q   <= 4'd0;
              end else begin
                shift_q     <= {shift_q[6:0], 1'b1};
                sda_drive_q <= ~shift_q[6];
              end
            end
          end
          RD_ACK: begin
            if (scl_rise) begin
              nack_q <= sda_s;
            end else if (scl_fall) begin
              if (nack_q) begin
                state_q <= IDLE;
              end else begin
                state_q <= RD_BYTE;
                load_q  <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign i2c_sda = sda_drive_q ? 1'b0 : 1'bz;

`ifdef I2C_TARGET_CLOCK_STRETCH_EN
  // SCL is held while a read byte is pending; the release follows the clock that sees tx_valid.
  assign i2c_scl = (state_q == RD_BYTE && load_q) ? 1'b0 : 1'bz;
`else
  assign i2c_scl = 1'bz;
`endif

  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign tx_ack      = tx_ack_q;
  assign tx_underrun = tx_underrun_q;
  assign busy        = busy_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2c_target.sv
// Bench for i2c_target: bus-level controller tasks, a vector table, randomized transactions
// against a transaction-level model, and hand-written repeated-start / reset / stretch sequences.
module tb_i2c_target;

  localparam int Q = 20;
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
  localparam int NV = 4;
`else
  localparam int NV = 5;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_o = 1'b1;
  logic       sda_o = 1'b1;
  wire        scl_bus;
  wire        sda_bus;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ack;
  logic       busy;
  logic       tx_underrun;
  logic [2:0] dbg_state;

  assign scl_bus = scl_o ? 1'bz : 1'b0;
  assign sda_bus = sda_o ? 1'bz : 1'b0;
  pullup (scl_bus);
  pullup (sda_bus);

  always #5 clk = ~clk;

  i2c_target #(.TARGET_ADDR(7'h1F)) dut (
    .clock      (clk),
    .reset      (rst),
    .i2c_scl    (scl_bus),
    .i2c_sda    (sda_bus),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ack     (tx_ack),
    .busy       (busy),
    .tx_underrun(tx_underrun),
    .dbg_state_o(dbg_state)
  );

  int total = 0;
  int bad = 0;

  // Monitor counters, only ever written here; the test reads deltas.
  int rxv_cnt = 0, txa_cnt = 0, txu_cnt = 0, dut_low_cnt = 0, busy_low_cnt = 0;
  always @(negedge clk) begin
    if (rx_valid === 1'b1) rxv_cnt++;
    if (tx_ack === 1'b1) txa_cnt++;
    if (tx_underrun === 1'b1) txu_cnt++;
    if (sda_o && sda_bus === 1'b0) dut_low_cnt++;
    if (busy !== 1'b1) busy_low_cnt++;
  end

  int b_rxv, b_txa, b_txu, b_low;
  task automatic snap();
    b_rxv = rxv_cnt;
    b_txa = txa_cnt;
    b_txu = txu_cnt;
    b_low = dut_low_cnt;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int max_stretch = 0;
  task automatic scl_release();
    int t;
    t = 0;
    scl_o = 1'b1;
    #1;
    while (scl_bus !== 1'b1 && t < 5000) begin
      @(posedge clk);
      #1;
      t++;
    end
    if (t > max_stretch) max_stretch = t;
    if (scl_bus !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL scl_release: scl=%b want 1 after %0d clocks", scl_bus, t);
    end
  endtask

  task automatic i2c_start();
    sda_o = 1'b1;
    wait_clks(Q / 2);
    scl_release();
    wait_clks(Q);
    sda_o = 1'b0;
    wait_clks(Q);
    scl_o = 1'b0;
  endtask

  task automatic i2c_stop();
    wait_clks(Q / 2);
    sda_o = 1'b0;
    wait_clks(Q / 2);
    scl_release();
    wait_clks(Q);
    sda_o = 1'b1;
    wait_clks(Q);
  endtask

  // One SCL period starting just after a falling edge; data changes mid-low, sampled mid-high.
  task automatic bit_xfer(input logic b, output logic r);
    wait_clks(Q / 2);
    sda_o = b;
    wait_clks(Q / 2);
    scl_release();
    wait_clks(Q / 2);
    r = sda_bus;
    wait_clks(Q / 2);
    scl_o = 1'b0;
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(nack, r);
  endtask

  logic       got_aack;
  logic       got_wack [4];
  logic [7:0] wbuf [4];
  logic [7:0] rbuf [4];
  logic       busy_mid;
  logic [2:0] state_mid;

  task automatic txn(input logic [7:0] ab, input int n);
    logic       a;
    logic [7:0] d;
    i2c_start();
    write_byte(ab, a);
    got_aack = a;
    for (int i = 0; i < n; i++) begin
      if (!ab[0]) begin
        write_byte(wbuf[i], a);
        got_wack[i] = a;
      end else begin
        read_byte(i == n - 1, d);
        rbuf[i] = d;
      end
    end
    wait_clks(6);
    busy_mid  = busy;
    state_mid = dbg_state;
    i2c_stop();
    wait_clks(4);
  endtask

  typedef struct {
    logic [7:0] ab;
    int         n;
    logic [7:0] d0;
    logic       txv;
    logic [7:0] txd;
    logic       e_ack;
    logic [7:0] e_rx;
    int         e_rxv;
    logic [7:0] e_rd;
    int         e_txa;
    int         e_txu;
    logic       e_busy;
    logic [2:0] e_state;
  } vec_t;

  vec_t       vt [5];
  logic [7:0] model_rx;
  logic [7:0] r_ab, r_txd, exp_rd;
  int         r_n;
  logic       r_txv, match, a0, a1, a2;
  logic [7:0] d;
  logic       rb;
  int         bl0;

  initial begin
    vt[0] = '{8'h3E, 1, 8'h20, 1'b0, 8'h00, 1'b1, 8'h20, 1, 8'hFF, 0, 0, 1'b1, 3'd3};
    vt[1] = '{8'h44, 1, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h20, 0, 8'hFF, 0, 0, 1'b0, 3'd0};
    vt[2] = '{8'h3F, 1, 8'h00, 1'b1, 8'hA5, 1'b1, 8'h20, 0, 8'hA5, 1, 0, 1'b1, 3'd0};
    vt[3] = '{8'h45, 1, 8'h00, 1'b1, 8'h96, 1'b0, 8'h20, 0, 8'hFF, 0, 0, 1'b0, 3'd0};
    vt[4] = '{8'h3F, 1, 8'h00, 1'b0, 8'h3C, 1'b1, 8'h20, 0, 8'hFF, 0, 1, 1'b1, 3'd0};

    // Reset state
    rst = 1'b1;
    wait_clks(5);
    chk("rst_sda", sda_bus, 1'b1);
    chk("rst_scl", scl_bus, 1'b1);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_flags", {rx_valid, tx_ack, tx_underrun, busy}, 4'b0000);
    chk("rst_state", dbg_state, 3'd0);
    rst = 1'b0;
    wait_clks(5);
    model_rx = 8'h00;

    // Vector table
    for (int i = 0; i < NV; i++) begin
      wbuf[0]  = vt[i].d0;
      tx_data  = vt[i].txd;
      tx_valid = vt[i].txv;
      snap();
      txn(vt[i].ab, vt[i].n);
      chk($sformatf("v%0d_addr_ack", i), got_aack, vt[i].e_ack);
      if (!vt[i].ab[0]) chk($sformatf("v%0d_data_ack", i), got_wack[0], vt[i].e_ack);
      else chk($sformatf("v%0d_rd_byte", i), rbuf[0], vt[i].e_rd);
      chk($sformatf("v%0d_rx_data", i), rx_data, vt[i].e_rx);
      chk($sformatf("v%0d_rx_valid_cnt", i), rxv_cnt - b_rxv, vt[i].e_rxv);
      chk($sformatf("v%0d_tx_ack_cnt", i), txa_cnt - b_txa, vt[i].e_txa);
      chk($sformatf("v%0d_underrun_cnt", i), txu_cnt - b_txu, vt[i].e_txu);
      chk($sformatf("v%0d_busy_mid", i), busy_mid, vt[i].e_busy);
      chk($sformatf("v%0d_busy_after", i), busy, 1'b0);
      chk($sformatf("v%0d_state", i), state_mid, vt[i].e_state);
      chk($sformatf("v%0d_dut_drove_sda", i), (dut_low_cnt - b_low) != 0, vt[i].e_ack);
      model_rx = vt[i].e_rx;
    end

    // Randomized transactions against the transaction-level model
    for (int k = 0; k < 12; k++) begin
      r_ab[7:1] = ($urandom_range(0, 1) == 0) ? 7'h1F : 7'($urandom_range(0, 127));
      r_ab[0]   = 1'($urandom_range(0, 1));
      r_n       = int'($urandom_range(1, 3));
`ifdef I2C_TARGET_CLOCK_STRETCH_EN
      r_txv = 1'b1;
`else
      r_txv = 1'($urandom_range(0, 1));
`endif
      r_txd = 8'($urandom_range(0, 255));
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom_range(0, 255));
      tx_data  = r_txd;
      tx_valid = r_txv;
      snap();
      txn(r_ab, r_n);
      match = (r_ab[7:1] == 7'h1F);
      if (match && !r_ab[0]) model_rx = wbuf[r_n - 1];
      exp_rd = (match && r_txv) ? r_txd : 8'hFF;
      chk($sformatf("r%0d_addr_ack", k), got_aack, match);
      for (int i = 0; i < r_n; i++) begin
        if (!r_ab[0]) chk($sformatf("r%0d_data_ack%0d", k, i), got_wack[i], match);
        else chk($sformatf("r%0d_rd_byte%0d", k, i), rbuf[i], exp_rd);
      end
      chk($sformatf("r%0d_rx_data", k), rx_data, model_rx);
      chk($sformatf("r%0d_rx_valid_cnt", k), rxv_cnt - b_rxv, (match && !r_ab[0]) ? r_n : 0);
      chk($sformatf("r%0d_tx_ack_cnt", k), txa_cnt - b_txa, (match && r_ab[0] && r_txv) ? r_n : 0);
      chk($sformatf("r%0d_underrun_cnt", k), txu_cnt - b_txu, (match && r_ab[0] && !r_txv) ? r_n : 0);
      chk($sformatf("r%0d_busy_mid", k), busy_mid, match);
      chk($sformatf("r%0d_busy_after", k), busy, 1'b0);
    end

    // Write, repeated START, read: busy must hold across the restart
    tx_data  = 8'h5C;
    tx_valid = 1'b1;
    snap();
    i2c_start();
    write_byte(8'h3E, a0);
    write_byte(8'h11, a1);
    bl0 = busy_low_cnt;
    i2c_start();
    write_byte(8'h3F, a2);
    read_byte(1'b1, d);
    wait_clks(6);
    chk("rs_busy_held", busy_low_cnt - bl0, 0);
    i2c_stop();
    wait_clks(4);
    chk("rs_acks", {a0, a1, a2}, 3'b111);
    chk("rs_rx_data", rx_data, 8'h11);
    chk("rs_rd_byte", d, 8'h5C);
    chk("rs_rx_valid_cnt", rxv_cnt - b_rxv, 1);
    chk("rs_tx_ack_cnt", txa_cnt - b_txa, 1);
    chk("rs_busy_after", busy, 1'b0);

    // Reset during bit 4 of a read byte of zeros, while the target is pulling SDA low
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    i2c_start();
    write_byte(8'h3F, a0);
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, rb);
    wait_clks(Q);
    scl_release();
    wait_clks(Q / 4);
    chk("mr_sda_low_before", sda_bus, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("mr_sda_released", sda_bus, 1'b1);
    chk("mr_rx_data", rx_data, 8'h00);
    chk("mr_busy", busy, 1'b0);
    wait_clks(2);
    rst = 1'b0;
    wait_clks(4);
    // Bus activity with no START must be ignored
    snap();
    wait_clks(Q / 2);
    scl_o = 1'b0;
    for (int i = 0; i < 9; i++) bit_xfer(1'(i % 2), rb);
    chk("mr_ignored_sda", dut_low_cnt - b_low, 0);
    chk("mr_ignored_state", dbg_state, 3'd0);
    wbuf[0] = 8'h77;
    txn(8'h3E, 1);
    chk("mr_addr_ack", got_aack, 1'b1);
    chk("mr_data_ack", got_wack[0], 1'b1);
    chk("mr_rx_data_after", rx_data, 8'h77);

`ifdef I2C_TARGET_CLOCK_STRETCH_EN
    // Read with no data ready: SCL held until tx_valid rises, then the byte goes out
    tx_valid = 1'b0;
    snap();
    i2c_start();
    write_byte(8'h3F, a0);
    max_stretch = 0;
    fork
      begin
        wait_clks(300);
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
      end
    join_none
    read_byte(1'b1, d);
    wait_clks(6);
    i2c_stop();
    wait_clks(4);
    chk("st_addr_ack", a0, 1'b1);
    chk("st_scl_held", max_stretch >= 250, 1'b1);
    chk("st_rd_byte", d, 8'hA5);
    chk("st_tx_ack_cnt", txa_cnt - b_txa, 1);
    chk("st_underrun_cnt", txu_cnt - b_txu, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 SHALL have parameter TARGET_ADDR, default 7'h1F, the 7-bit address this target answers to.
REQ-002 SHALL have port clock  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port i2c_scl  inout  1  bus clock, open-drain; only ever driven 0 or Z.
REQ-005 SHALL have port i2c_sda  inout  1  bus data, open-drain; only ever driven 0 or Z.
REQ-006 SHALL have port rx_data  output  8  last byte written by the controller.
REQ-007 SHALL have port rx_valid  output  1  one-clock pulse when rx_data is updated.
REQ-008 SHALL have port tx_data  input  8  byte to return on a controller read.
REQ-009 SHALL have port tx_valid  input  1  tx_data is available.
REQ-010 SHALL have port tx_ack  output  1  one-clock pulse when tx_data is latched into the shifter.
REQ-011 SHALL have port busy  output  1  high from an addressed START to the STOP.
REQ-012 SHALL have port tx_underrun  output  1  one-clock pulse when a read byte is needed while tx_valid=0.

Function
REQ-013 SHALL pass SCL and SDA through 2-flop synchronizers and detect edges on the synchronized values.
REQ-014 SHALL detect START (SDA fall while SCL=1) and STOP (SDA rise while SCL=1) in any state.
REQ-015 SHALL use states IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK.
REQ-016 SHALL go to ADDR on any START, including a repeated START mid-transfer, and to IDLE on any STOP, releasing SDA.
REQ-017 SHALL sample SDA on SCL rising edges, MSB first, and change its own SDA only on SCL falling edges.
REQ-018 SHALL, in ADDR, after 8 bits compare bits[7:1] with TARGET_ADDR. On mismatch: go to IDLE and never drive SDA. On match: drive ACK (SDA=0) for the 9th SCL period.
REQ-019 SHALL, after ADDR_ACK, enter WR_BYTE if R/W=0, or RD_BYTE if R/W=1.
REQ-020 SHALL, in WR_BYTE, after the 8th rising edge update rx_data, pulse rx_valid one clock later, then ACK the byte in WR_ACK.
REQ-021 SHALL, entering RD_BYTE (ADDR_ACK or RD_ACK falling edge), latch tx_data and pulse tx_ack if tx_valid=1; otherwise latch 8'hFF and pulse tx_underrun.
REQ-022 SHALL drive each read bit as 0 or Z, then release SDA in RD_ACK and sample the controller's bit. ACK (0) returns to RD_BYTE; NACK (1) goes to IDLE-wait-for-STOP.
REQ-023 SHALL hold busy=1 from the ADDR_ACK entry on a match until STOP or a non-matching repeated START.
REQ-024 SHALL keep a 4-bit bit counter that wraps 0..8 per byte and is cleared on every START.
REQ-025 SHALL have a response latency (SCL falling edge to SDA change) of at most 4 clock cycles.
REQ-026 SHALL ignore SCL/SDA activity without a preceding START.

Reset
REQ-027 SHALL, while reset=1, go to IDLE with SDA and SCL released (Z), rx_data=8'h00, and rx_valid=tx_ack=tx_underrun=busy=0.
REQ-028 SHALL, on reset asserted mid-transfer, release the bus within one clock and wait for a fresh START.

Configuration
REQ-029 SHALL support macro I2C_TARGET_CLOCK_STRETCH_EN.
REQ-030 SHALL, with I2C_TARGET_CLOCK_STRETCH_EN defined, hold SCL low on entry to RD_BYTE while tx_valid=0, then release it one clock after tx_valid=1. In this mode tx_underrun is never pulsed.
REQ-031 SHALL, without I2C_TARGET_CLOCK_STRETCH_EN, never drive i2c_scl and use the 8'hFF underrun rule.

Verification
REQ-032 SHALL cover write 0x1F (8'h3E) then data 8'h20 -> ACK on both 9th bits; rx_data=8'h20, one rx_valid pulse, busy low after STOP.
REQ-033 SHALL cover address 7'h22 written -> SDA never driven low; busy stays 0; no rx_valid.
REQ-034 SHALL cover read 0x1F (8'h3F), tx_data=8'hA5, tx_valid=1, controller NACKs -> bus shows 8'hA5; one tx_ack; state IDLE.
REQ-035 SHALL cover a read with tx_valid=0 -> without the macro: 8'hFF and a tx_underrun pulse; with the macro: SCL held low until tx_valid rises, then 8'hA5 is sent.
REQ-036 SHALL cover write 8'h3E, data 8'h11, repeated START, read 8'h3F -> rx_data=8'h11, read data returned, busy high throughout.
REQ-037 SHALL cover reset asserted during bit 4 of a data byte -> SDA released within one clock; next transfer with address 0x1F is ACKed normally.
